// File: rtl/segled_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// CTRL field positions and the hex glyph table (active-high, g..a).
package segled_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DATA   = 3'd1;
  localparam logic [2:0] ADDR_POINT  = 3'd2;
  localparam logic [2:0] ADDR_BLANK  = 3'd3;
  localparam logic [2:0] ADDR_BLINK  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_BRIGHT_LSB   = 8;
  localparam int unsigned CTRL_BLINK_EN_BIT = 16;
  localparam int unsigned STATUS_PEND_BIT   = 8;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/segled_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for the scan controller (read latency 1, no waitrequest).
interface segled_scan_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/segled_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern (g..a).
module segled_hex_decode
  import segled_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end
endmodule

// File: rtl/segled_scan_ctrl.sv
// N-digit multiplexed seven-segment controller: Avalon-MM register file,
// double-buffered display state, PWM brightness, blink/blank, registered pins.
module segled_scan_ctrl
  import segled_pkg::*;
#(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned SUB_CYCLES     = 3125,
  parameter int unsigned BLINK_FRAMES   = 42,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  segled_scan_ctrl_if.slave  avs,
  output logic [DIGITS-1:0]  sel,
  output logic [7:0]         seg_led
);

  localparam int unsigned DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SW     = $clog2(SUB_CYCLES);
  localparam int unsigned BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DATA_W = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("segled_scan_ctrl: DIGITS must be in 1..8");
  end
  if (SUB_CYCLES < 2) begin : g_bad_sub
    $error("segled_scan_ctrl: SUB_CYCLES must be at least 2");
  end

  logic              en_q, en_d, blink_en_q, blink_en_d;
  logic [3:0]        bright_q, bright_d;
  logic [DATA_W-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0] sh_point_q, sh_point_d, act_point_q, act_point_d;
  logic [DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0] sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic              pending_q, pending_d, phase_q, phase_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic [3:0]        slot_q, slot_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic              commit, wr, frame_wrap;
  logic [DATA_W-1:0] eff_data;
  logic [DIGITS-1:0] eff_point, eff_blank, eff_blink, dmask;
  logic [3:0]        nibble;
  logic [6:0]        glyph;
  logic              lit;
  logic              unused_wd;

  assign unused_wd        = ^avs.avs_writedata;
  assign wr               = avs.avs_write;
  assign avs.avs_readdata = rdata_q;
  assign sel              = sel_q;
  assign seg_led          = seg_q;

  // Counters at (0,0,0) with EN set marks the first cycle of a frame, including
  // the restart right after EN rises, so that is the single commit cycle.
  assign commit = en_q && (sub_q == '0) && (slot_q == '0) && (digit_q == '0);

  // The frame starting now must already show the committed values.
  assign eff_data  = commit ? sh_data_q  : act_data_q;
  assign eff_point = commit ? sh_point_q : act_point_q;
  assign eff_blank = commit ? sh_blank_q : act_blank_q;
  assign eff_blink = commit ? sh_blink_q : act_blink_q;
  assign dmask     = DIGITS'(1) << digit_q;
  assign nibble    = 4'(eff_data >> {digit_q, 2'b00});

  segled_hex_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    sub_d      = '0;
    slot_d     = '0;
    digit_d    = '0;
    bcnt_d     = '0;
    phase_d    = 1'b0;
    frame_wrap = 1'b0;
    if (en_q) begin
      sub_d   = (sub_q == SW'(SUB_CYCLES - 1)) ? '0 : sub_q + 1'b1;
      slot_d  = slot_q;
      digit_d = digit_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (sub_q == SW'(SUB_CYCLES - 1)) begin
        slot_d = slot_q + 4'd1;
        if (slot_q == 4'hF) begin
          digit_d    = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
          frame_wrap = (digit_q == DW'(DIGITS - 1));
        end
      end
      if (frame_wrap) begin
        if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    en_d        = en_q;
    bright_d    = bright_q;
    blink_en_d  = blink_en_q;
    sh_data_d   = sh_data_q;
    sh_point_d  = sh_point_q;
    sh_blank_d  = sh_blank_q;
    sh_blink_d  = sh_blink_q;
    act_data_d  = commit ? sh_data_q  : act_data_q;
    act_point_d = commit ? sh_point_q : act_point_q;
    act_blank_d = commit ? sh_blank_q : act_blank_q;
    act_blink_d = commit ? sh_blink_q : act_blink_q;
    pending_d   = commit ? 1'b0 : pending_q;
    if (wr) begin
      unique case (avs.avs_address)
        ADDR_CTRL: begin
          en_d       = avs.avs_writedata[CTRL_EN_BIT];
          bright_d   = avs.avs_writedata[CTRL_BRIGHT_LSB +: 4];
          blink_en_d = avs.avs_writedata[CTRL_BLINK_EN_BIT];
        end
        ADDR_DATA:  begin sh_data_d  = avs.avs_writedata[DATA_W-1:0]; pending_d = 1'b1; end
        ADDR_POINT: begin sh_point_d = avs.avs_writedata[DIGITS-1:0]; pending_d = 1'b1; end
        ADDR_BLANK: begin sh_blank_d = avs.avs_writedata[DIGITS-1:0]; pending_d = 1'b1; end
        ADDR_BLINK: begin sh_blink_d = avs.avs_writedata[DIGITS-1:0]; pending_d = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (avs.avs_read) begin
      unique case (avs.avs_address)
        ADDR_CTRL: begin
          rdata_d[CTRL_EN_BIT]           = en_q;
          rdata_d[CTRL_BRIGHT_LSB +: 4]  = bright_q;
          rdata_d[CTRL_BLINK_EN_BIT]     = blink_en_q;
        end
        ADDR_DATA:   rdata_d = 32'(sh_data_q);
        ADDR_POINT:  rdata_d = 32'(sh_point_q);
        ADDR_BLANK:  rdata_d = 32'(sh_blank_q);
        ADDR_BLINK:  rdata_d = 32'(sh_blink_q);
        ADDR_STATUS: begin
          rdata_d[2:0]             = 3'(digit_q);
          rdata_d[STATUS_PEND_BIT] = pending_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lit = en_q && (slot_q < bright_q) && ((eff_blank & dmask) == '0) &&
          !(blink_en_q && ((eff_blink & dmask) != '0) && phase_q);
    sel_d = lit ? dmask : '0;
    seg_d = lit ? {((eff_point & dmask) != '0), glyph} : 8'h00;
    if (SEL_ACTIVE_LOW) sel_d = ~sel_d;
    if (SEG_ACTIVE_LOW) seg_d = ~seg_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      bright_q    <= '0;
      blink_en_q  <= 1'b0;
      sh_data_q   <= '0;
      sh_point_q  <= '0;
      sh_blank_q  <= '0;
      sh_blink_q  <= '0;
      act_data_q  <= '0;
      act_point_q <= '0;
      act_blank_q <= '0;
      act_blink_q <= '0;
      pending_q   <= 1'b0;
      phase_q     <= 1'b0;
      sub_q       <= '0;
      slot_q      <= '0;
      digit_q     <= '0;
      bcnt_q      <= '0;
      rdata_q     <= '0;
      sel_q       <= {DIGITS{SEL_ACTIVE_LOW}};
      seg_q       <= {8{SEG_ACTIVE_LOW}};
    end else begin
      en_q        <= en_d;
      bright_q    <= bright_d;
      blink_en_q  <= blink_en_d;
      sh_data_q   <= sh_data_d;
      sh_point_q  <= sh_point_d;
      sh_blank_q  <= sh_blank_d;
      sh_blink_q  <= sh_blink_d;
      act_data_q  <= act_data_d;
      act_point_q <= act_point_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
      pending_q   <= pending_d;
      phase_q     <= phase_d;
      sub_q       <= sub_d;
      slot_q      <= slot_d;
      digit_q     <= digit_d;
      bcnt_q      <= bcnt_d;
      rdata_q     <= rdata_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

endmodule

// File: tb/tb_segled_scan_ctrl.sv
// Directed bench for segled_scan_ctrl with DIGITS=4, SUB_CYCLES=2, BLINK_FRAMES=2 (128-clock frame).
module tb_segled_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sel;
  logic [7:0] seg_led;

  always #5 clk = ~clk;

  segled_scan_ctrl_if bus ();

  segled_scan_ctrl #(
    .DIGITS         (4),
    .SUB_CYCLES     (2),
    .BLINK_FRAMES   (2),
    .SEL_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .avs     (bus),
    .sel     (sel),
    .seg_led (seg_led)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         lit_cnt [4];
  logic [7:0] seg_seen [4];
  int         bad_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wait_sel(input logic [3:0] v, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sel == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic observe(input int ncyc);
    for (int d = 0; d < 4; d++) begin
      lit_cnt[d]  = 0;
      seg_seen[d] = 8'hFF;
    end
    bad_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      case (sel)
        4'b1110: begin lit_cnt[0]++; seg_seen[0] = seg_led; end
        4'b1101: begin lit_cnt[1]++; seg_seen[1] = seg_led; end
        4'b1011: begin lit_cnt[2]++; seg_seen[2] = seg_led; end
        4'b0111: begin lit_cnt[3]++; seg_seen[3] = seg_led; end
        4'b1111: if (seg_led != 8'hFF) bad_cnt++;
        default: bad_cnt++;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        ok;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sel", 32'(sel), 32'hF);
    chk("reset_seg", 32'(seg_led), 32'hFF);
    rst_n = 1'b1;
    bus_read(3'd0, r);
    chk("reset_ctrl", r, 32'h0);
    bus_read(3'd5, r);
    chk("reset_status", r, 32'h0);

    // Basic scan at full brightness
    bus_write(3'd1, 32'h3210);
    bus_write(3'd2, 32'h4);
    bus_write(3'd0, 32'h0F01);
    repeat (4) @(negedge clk);
    observe(128);
    for (int d = 0; d < 4; d++) chk($sformatf("b15_lit%0d", d), 32'(lit_cnt[d]), 32'd30);
    chk("seg_d0", 32'(seg_seen[0]), 32'hC0);
    chk("seg_d1", 32'(seg_seen[1]), 32'hF9);
    chk("seg_d2", 32'(seg_seen[2]), 32'h24);
    chk("seg_d3", 32'(seg_seen[3]), 32'hB0);
    chk("b15_bad", 32'(bad_cnt), 32'd0);

    // PWM duty
    bus_write(3'd0, 32'h0401);
    repeat (4) @(negedge clk);
    observe(128);
    for (int d = 0; d < 4; d++) chk($sformatf("b4_lit%0d", d), 32'(lit_cnt[d]), 32'd8);
    bus_write(3'd0, 32'h0001);
    repeat (4) @(negedge clk);
    observe(128);
    chk("b0_lit", 32'(lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 32'd0);
    chk("b0_bad", 32'(bad_cnt), 32'd0);

    // Double buffering
    bus_write(3'd0, 32'h0F01);
    wait_sel(4'b1110, ok);
    chk("db_wait0", 32'(ok), 32'd1);
    wait_sel(4'b1101, ok);
    chk("db_wait1", 32'(ok), 32'd1);
    bus_write(3'd1, 32'hFFFF);
    bus_read(3'd5, r);
    chk("db_pending", 32'(r[8]), 32'd1);
    chk("db_digit", 32'(r[2:0]), 32'd1);
    wait_sel(4'b0111, ok);
    chk("db_wait3", 32'(ok), 32'd1);
    chk("db_old_d3", 32'(seg_led), 32'hB0);
    wait_sel(4'b1110, ok);
    chk("db_wrap", 32'(ok), 32'd1);
    chk("db_new_d0", 32'(seg_led), 32'h8E);
    bus_read(3'd5, r);
    chk("db_cleared", 32'(r[8]), 32'd0);

    // Blink and blank
    bus_write(3'd3, 32'h1);
    bus_write(3'd4, 32'h2);
    bus_write(3'd0, 32'h10F01);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus_read(3'd5, r);
      if (!r[8]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bb_commit", 32'(ok), 32'd1);
    observe(1024);
    chk("bb_lit0", 32'(lit_cnt[0]), 32'd0);
    chk("bb_lit1", 32'(lit_cnt[1]), 32'd120);
    chk("bb_lit2", 32'(lit_cnt[2]), 32'd240);
    chk("bb_lit3", 32'(lit_cnt[3]), 32'd240);
    chk("bb_seg1", 32'(seg_seen[1]), 32'h8E);
    chk("bb_seg2", 32'(seg_seen[2]), 32'h0E);
    chk("bb_bad", 32'(bad_cnt), 32'd0);

    // Readback and register masking
    bus_write(3'd0, 32'hFFFFFFFF);
    bus_read(3'd0, r);
    chk("rb_ctrl", r, 32'h00010F01);
    bus_write(3'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("en0_sel", 32'(sel), 32'hF);
    chk("en0_seg", 32'(seg_led), 32'hFF);
    bus_write(3'd1, 32'hFFFFABCD);
    bus_read(3'd1, r);
    chk("rb_data", r, 32'h0000ABCD);
    bus_write(3'd2, 32'hFFFFFFF5);
    bus_read(3'd2, r);
    chk("rb_point", r, 32'h5);
    bus_write(3'd3, 32'hA);
    bus_read(3'd3, r);
    chk("rb_blank", r, 32'hA);
    bus_write(3'd4, 32'h6);
    bus_read(3'd4, r);
    chk("rb_blink", r, 32'h6);
    bus_read(3'd6, r);
    chk("rb_addr6", r, 32'h0);
    bus_write(3'd5, 32'hFFFFFFFF);
    bus_read(3'd5, r);
    chk("rb_status", r, 32'h100);
    bus_write(3'd7, 32'hFFFFFFFF);
    bus_read(3'd7, r);
    chk("rb_addr7", r, 32'h0);
    bus_read(3'd0, r);
    chk("rb_ctrl_kept", r, 32'h0);

    // Reset mid-frame discards everything
    bus_write(3'd0, 32'h0F01);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_sel", 32'(sel), 32'hF);
    chk("mrst_seg", 32'(seg_led), 32'hFF);
    rst_n = 1'b1;
    bus_read(3'd1, r);
    chk("mrst_data", r, 32'h0);
    bus_read(3'd5, r);
    chk("mrst_status", r, 32'h0);
    bus_read(3'd0, r);
    chk("mrst_ctrl", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
